// File: rtl/pipeline_controller_pkg.sv
// pipe_ctrl_pkg: shared state encoding and register-file index constants
// for the pipeline stall/flush sequencer.
`default_nettype none

package pipe_ctrl_pkg;

    localparam int RF_IDX_W = 5;
    localparam logic [RF_IDX_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_controller_hazard_detect.sv
// hazard_detect: combinational load-use compare between the ID sources
// and the EX destination.
`default_nettype none

module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [RF_IDX_W-1:0] id_rs1_i,
    input  logic [RF_IDX_W-1:0] id_rs2_i,
    input  logic                id_uses_rs1_i,
    input  logic                id_uses_rs2_i,
    input  logic [RF_IDX_W-1:0] ex_rd_i,
    input  logic                ex_is_load_i,
    output logic                load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

    // x0 is never written, so a load targeting it cannot create a hazard.
    assign load_use_o = ex_is_load_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush sequencer for the 5-stage RV32I pipeline.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
`default_nettype none

module pipeline_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                imem_resp,
    input  logic                dmem_busy,
    input  logic [RF_IDX_W-1:0] id_rs1,
    input  logic [RF_IDX_W-1:0] id_rs2,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic [RF_IDX_W-1:0] ex_rd,
    input  logic                ex_is_load,
    input  logic                ex_br_taken,
    input  logic [WIDTH-1:0]    ex_br_target,
    output logic                load_pc,
    output logic                load_if_id,
    output logic                load_id_ex,
    output logic                load_ex_mem,
    output logic                load_mem_wb,
    output logic                clr_if_id,
    output logic                clr_id_ex,
    output logic                pc_redirect,
    output logic [WIDTH-1:0]    redirect_target,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         squash_count
);

    ctrl_state_t      state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .ex_rd_i       (ex_rd),
        .ex_is_load_i  (ex_is_load),
        .load_use_o    (load_use)
    );

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        load_pc         = 1'b0;
        load_if_id      = 1'b0;
        load_id_ex      = 1'b0;
        load_ex_mem     = 1'b0;
        load_mem_wb     = 1'b0;
        clr_if_id       = 1'b0;
        clr_id_ex       = 1'b0;
        pc_redirect     = 1'b0;
        redirect_target = ex_br_target;

        if (!reset_n) begin
            clr_if_id = 1'b1;
            clr_id_ex = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (dmem_busy) begin
                        // Whole pipe frozen; a taken branch stays in EX and is seen again.
                    end else if (ex_br_taken && imem_resp) begin
                        load_pc     = 1'b1;
                        pc_redirect = 1'b1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        clr_if_id   = 1'b1;
                        clr_id_ex   = 1'b1;
                    end else if (ex_br_taken) begin
                        // Fetch still in flight: park the target until it lands.
                        state_d     = SQUASH;
                        target_d    = ex_br_target;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        clr_id_ex   = 1'b1;
                    end else if (load_use) begin
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        clr_id_ex   = 1'b1;
                    end else if (!imem_resp) begin
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        clr_if_id   = 1'b1;
                    end else begin
                        load_pc     = 1'b1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end
                end
                SQUASH: begin
                    redirect_target = target_q;
                    clr_id_ex       = 1'b1;
                    load_id_ex      = !dmem_busy;
                    load_ex_mem     = !dmem_busy;
                    load_mem_wb     = !dmem_busy;
                    // Front end completes the redirect regardless of the back end.
                    if (imem_resp) begin
                        load_pc     = 1'b1;
                        pc_redirect = 1'b1;
                        clr_if_id   = 1'b1;
                        state_d     = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] squash_q, squash_d;

    assign stall_d  = stall_q + {31'd0, ~load_pc};
    assign squash_d = squash_q + {31'd0, pc_redirect};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q  <= '0;
            squash_q <= '0;
        end else begin
            stall_q  <= stall_d;
            squash_q <= squash_d;
        end
    end

    assign stall_cycles = stall_q;
    assign squash_count = squash_q;
`else
    assign stall_cycles = 32'd0;
    assign squash_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the 5-stage RV32I pipeline. It drives the load and synchronous-clear inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It resolves data-memory stalls, instruction-fetch stalls, load-use hazards and taken-branch redirects, including redirects that arrive while an instruction fetch is still in flight. It sits beside the datapath top and contains no datapath state other than a pending-redirect target.

## Interface
- WIDTH, 32, PC/branch-target width
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- imem_resp  in  1  fetch for current PC completes this cycle (single-cycle pulse)
- dmem_busy  in  1  MEM-stage access outstanding, no response this cycle
- id_rs1, id_rs2  in  5  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  source operand actually read
- ex_rd  in  5  destination of instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_br_taken  in  1  EX resolved a taken branch/jump
- ex_br_target  in  WIDTH  redirect address
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1  register load enables
- clr_if_id, clr_id_ex  out  1  synchronous clear (bubble insert); an all-zero stage word is a bubble
- pc_redirect  out  1  PC mux selects redirect_target
- redirect_target  out  WIDTH  target to load into PC
- stall_cycles, squash_count  out  32  performance counters

## Operation
- States: RUN, SQUASH. Outputs are Mealy-combinational from state and inputs; state, target register and counters update on posedge clk.
- While reset_n is low, all load_* = 0, clr_* = 1, pc_redirect = 0, state = RUN, target register = 0, counters = 0.
- RUN priority, highest first:
  1. dmem_busy: freeze. All load_* = 0, clr_* = 0. A pending branch in EX is held and re-evaluated next cycle.
  2. ex_br_taken && imem_resp: immediate redirect. load_pc = 1, pc_redirect = 1, redirect_target = ex_br_target. clr_if_id = clr_id_ex = 1. All stage loads = 1.
  3. ex_br_taken && !imem_resp: capture ex_br_target, go to SQUASH. load_pc = load_if_id = 0. clr_id_ex = 1. load_ex_mem = load_mem_wb = 1.
  4. Load-use: ex_is_load && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)). load_pc = load_if_id = 0. clr_id_ex = 1. EX/MEM and MEM/WB load. A fetch completing this cycle is discarded and refetched.
  5. !imem_resp: load_pc = 0, clr_if_id = 1, downstream stages load.
  6. Otherwise all loads = 1, clears = 0.
- SQUASH:
  - clr_id_ex = 1 every cycle; load_pc = load_if_id = 0.
  - EX/MEM and MEM/WB load unless dmem_busy.
  - On imem_resp: load_pc = 1, pc_redirect = 1 with the stored target, clr_if_id = 1, next state RUN. This happens even while dmem_busy, because the front end is independent.
  - ex_br_taken in SQUASH is ignored, since EX holds a bubble. The bench asserts it never occurs.
- A clear asserted together with a load yields zero in the stage register.

## Timing
- Immediate redirect: target is fetched in the cycle after ex_br_taken; 2 wrong-path slots are squashed.
- Deferred redirect: PC loads target at the edge where imem_resp = 1 in SQUASH.
- Load-use: exactly 1 bubble per hazard cycle.
- Fetch stall: 1 bubble per cycle without imem_resp.
- redirect_target is driven combinationally from ex_br_target in RUN and from the target register in SQUASH.
- reset_n deassertion mid-SQUASH is not special: assertion at any time returns the block to RUN and drops the pending target.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with load_pc = 0 outside reset.
  - squash_count increments on every redirect (pc_redirect = 1).
  - Both counters wrap at 2^32.
- PIPE_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package pipe_ctrl_pkg: enum ctrl_state_t {RUN, SQUASH}, localparam REG_X0 = 5'd0, localparam RF_IDX_W = 5.
- Sub-module hazard_detect: combinational load-use compare over id_rs*/id_uses_rs*/ex_rd/ex_is_load, output load_use.

## Test plan
- Reset held 3 cycles -> all loads 0, clr_if_id = clr_id_ex = 1. After release, with imem_resp = 1 and no hazards, all loads = 1 on cycle 1.
- ex_is_load = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 -> one cycle of load_pc = 0, clr_id_ex = 1. With ex_rd = 0 there is no stall.
- ex_br_taken = 1, target 0x0000_0100, imem_resp = 1 -> same cycle pc_redirect = 1, redirect_target = 0x100, both clears = 1, squash_count += 1.
- ex_br_taken = 1, target 0x200, imem_resp = 0 for 4 cycles then 1 -> SQUASH for 4 cycles with clr_id_ex = 1. On the 5th cycle pc_redirect = 1, redirect_target = 0x200, then RUN.
- dmem_busy = 1 for 3 cycles with ex_br_taken = 1 -> all loads 0 for 3 cycles. Redirect occurs on the 4th; stall_cycles += 3 (+0 for the redirect cycle).
- SQUASH with dmem_busy = 1 and imem_resp = 1 -> load_pc = 1, pc_redirect = 1, load_ex_mem = 0, next state RUN.
